// File: rtl/prng_lfsr_stream.sv
// Fibonacci-LFSR word generator with seed load, zero-seed substitution, optional whitening
// and a valid/ready output stream. States: GEN | stepping and collecting bits; HOLD | one finished word parked in col.
module prng_lfsr_stream #(
  parameter int                 STATE_W      = 16,
  parameter int                 OUT_W        = 8,
  parameter logic [STATE_W-1:0] TAPS         = 16'hD008,
  parameter logic [STATE_W-1:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               whiten,
  input  logic               seed_valid,
  input  logic [STATE_W-1:0] seed_data,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               seed_fixed
);

  localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  typedef enum logic {GEN = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [STATE_W-1:0] s_q, s_step, seed_eff;
  logic [OUT_W-1:0]   col_q, col_step, hi_slice, lo_slice, word;
  logic [CNT_W-1:0]   cnt_q;
  logic               fb, seed_zero;
  logic               step, word_done, direct_load, hold_release, handshake;

  always_comb begin
    fb        = ^(s_q & TAPS);
    s_step    = {s_q[STATE_W-2:0], fb};
    col_step  = (col_q << 1) | OUT_W'(s_q[STATE_W-1]);
    hi_slice  = s_step[STATE_W-1 -: OUT_W];
    lo_slice  = s_step[OUT_W-1:0];
    // rotations are confined to OUT_W bits; OUT_W==1 degenerates to identity
    word      = col_step;
    if (whiten)
      word = col_step ^ ((hi_slice << 1) | (hi_slice >> (OUT_W - 1)))
                      ^ ((lo_slice >> 1) | (lo_slice << (OUT_W - 1)));
    seed_zero = (seed_data == '0);
    seed_eff  = seed_zero ? DEFAULT_SEED : seed_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= GEN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (seed_valid) begin
      state_d = GEN;
    end else begin
      case (state_q)
        GEN:     if (word_done && !direct_load) state_d = HOLD;
        HOLD:    if (out_ready) state_d = GEN;
        default: state_d = GEN;
      endcase
    end
  end

  always_comb begin
    handshake    = out_valid && out_ready;
    step         = (state_q == GEN) && en && !seed_valid;
    word_done    = step && (cnt_q == CNT_LAST);
    direct_load  = word_done && (!out_valid || out_ready);
    hold_release = (state_q == HOLD) && out_ready && !seed_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= DEFAULT_SEED;
      col_q      <= '0;
      cnt_q      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      seed_fixed <= 1'b0;
    end else begin
      seed_fixed <= 1'b0;
      if (seed_valid) begin
        s_q        <= seed_eff;
        col_q      <= '0;
        cnt_q      <= '0;
        out_valid  <= 1'b0;
        seed_fixed <= seed_zero;
      end else begin
        if (step) begin
          s_q <= s_step;
          if (word_done) begin
            cnt_q <= '0;
            // a word that cannot be handed off is parked in the collector
            col_q <= direct_load ? col_step : word;
          end else begin
            col_q <= col_step;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        if (direct_load) begin
          out_data  <= word;
          out_valid <= 1'b1;
        end else if (hold_release) begin
          out_data  <= col_q;
        end else if (handshake) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
